// File: rtl/tp_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tp_gen_multi
// Brief    : Test pattern generator for the TG path. Free-running H/V/field
//            counters, registered DE/HS/VS and four selectable RGB patterns.
// Revision : 1.0  initial release
// ============================================================================
module tp_gen_multi #(
  parameter int C_W      = 8,
  parameter int CTR_W    = 16,
  parameter int F_W      = 8,
  parameter int H_TOTAL  = 910,
  parameter int H_ACT    = 720,
  parameter int H_SYNC_S = 736,
  parameter int H_SYNC_W = 64,
  parameter int V_TOTAL  = 262,
  parameter int V_ACT    = 240,
  parameter int V_SYNC_S = 244,
  parameter int V_SYNC_W = 3,
  parameter int CHK_LOG2 = 4
) (
  input  logic             CK_i,
  input  logic             RST_i,
  input  logic             CK_EE_i,
  input  tri1              XVRST_i,
  input  logic [1:0]       MODE_i,
  input  logic [C_W-1:0]   FLAT_R_i,
  input  logic [C_W-1:0]   FLAT_G_i,
  input  logic [C_W-1:0]   FLAT_B_i,
  output logic [C_W-1:0]   QQs_R_o,
  output logic [C_W-1:0]   QQs_G_o,
  output logic [C_W-1:0]   QQs_B_o,
  output logic             DE_o,
  output logic             HS_o,
  output logic             VS_o,
  output logic [CTR_W-1:0] HCTRs_o,
  output logic [CTR_W-1:0] VCTRs_o,
  output logic [F_W-1:0]   FCTRs_o
);

  localparam logic [CTR_W-1:0] H_LAST  = CTR_W'(H_TOTAL - 1);
  localparam logic [CTR_W-1:0] V_LAST  = CTR_W'(V_TOTAL - 1);
  localparam logic [CTR_W-1:0] BW_LAST = CTR_W'(H_ACT / 8 - 1);
  localparam logic [CTR_W:0]   H_ACT_L = (CTR_W+1)'(H_ACT);
  localparam logic [CTR_W:0]   V_ACT_L = (CTR_W+1)'(V_ACT);
  localparam logic [CTR_W:0]   HS_BEG  = (CTR_W+1)'(H_SYNC_S);
  localparam logic [CTR_W:0]   HS_END  = (CTR_W+1)'(H_SYNC_S + H_SYNC_W);
  localparam logic [CTR_W:0]   VS_BEG  = (CTR_W+1)'(V_SYNC_S);
  localparam logic [CTR_W:0]   VS_END  = (CTR_W+1)'(V_SYNC_S + V_SYNC_W);
  localparam logic [C_W-1:0]   ONES    = {C_W{1'b1}};

  logic [CTR_W-1:0] hctr_q, hctr_d, vctr_q, vctr_d;
  logic [F_W-1:0]   fctr_q, fctr_d;
  logic             xvrst_dly_q, xvrst_dly_d;
  logic [1:0]       mode_q, mode_d;
  logic [CTR_W-1:0] bar_pos_q, bar_pos_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [C_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  logic             vrst, h_wrap, v_last, frame_wrap;
  logic [CTR_W:0]   h_ext, v_ext;
  logic [CTR_W-1:0] fctr_c;
  logic             pix_de, pix_hs, pix_vs, chk_sel;
  logic [C_W-1:0]   pix_r, pix_g, pix_b;

  // Pixel value for the current counter position, registered below
  always_comb begin
    h_ext   = {1'b0, hctr_q};
    v_ext   = {1'b0, vctr_q};
    fctr_c  = CTR_W'(fctr_q);
    pix_de  = (h_ext < H_ACT_L) && (v_ext < V_ACT_L);
    pix_hs  = (h_ext >= HS_BEG) && (h_ext < HS_END);
    pix_vs  = (v_ext >= VS_BEG) && (v_ext < VS_END);
    chk_sel = 1'((hctr_q + fctr_c) >> CHK_LOG2) ^ vctr_q[CHK_LOG2];
    pix_r   = '0;
    pix_g   = '0;
    pix_b   = '0;
    if (pix_de) begin
      case (mode_q)
        2'd0: begin
          pix_r = hctr_q[C_W-1:0];
          pix_g = C_W'(vctr_q + fctr_c + hctr_q);
          pix_b = vctr_q[C_W-1:0];
        end
        2'd1: begin
          // Bar order white..black maps onto inverted index bits
          pix_r = bar_idx_q[1] ? '0 : ONES;
          pix_g = bar_idx_q[2] ? '0 : ONES;
          pix_b = bar_idx_q[0] ? '0 : ONES;
        end
        2'd2: begin
          pix_r = chk_sel ? ONES : '0;
          pix_g = chk_sel ? ONES : '0;
          pix_b = chk_sel ? ONES : '0;
        end
        default: begin
          pix_r = FLAT_R_i;
          pix_g = FLAT_G_i;
          pix_b = FLAT_B_i;
        end
      endcase
    end
  end

  always_comb begin
    vrst        = xvrst_dly_q & ~XVRST_i;
    h_wrap      = (hctr_q == H_LAST);
    v_last      = (vctr_q == V_LAST);
    frame_wrap  = h_wrap & v_last;
    hctr_d      = hctr_q;
    vctr_d      = vctr_q;
    fctr_d      = fctr_q;
    xvrst_dly_d = xvrst_dly_q;
    mode_d      = mode_q;
    bar_pos_d   = bar_pos_q;
    bar_idx_d   = bar_idx_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    de_d        = de_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    if (CK_EE_i) begin
      xvrst_dly_d = XVRST_i;
      r_d         = pix_r;
      g_d         = pix_g;
      b_d         = pix_b;
      de_d        = pix_de;
      hs_d        = pix_hs;
      vs_d        = pix_vs;
      if (frame_wrap || vrst) begin
        mode_d = MODE_i;
      end
      if (vrst) begin
        hctr_d    = '0;
        vctr_d    = '0;
        bar_pos_d = '0;
        bar_idx_d = '0;
      end else if (h_wrap) begin
        hctr_d    = '0;
        bar_pos_d = '0;
        bar_idx_d = '0;
        if (v_last) begin
          vctr_d = '0;
          fctr_d = fctr_q + F_W'(1);
        end else begin
          vctr_d = vctr_q + CTR_W'(1);
        end
      end else begin
        hctr_d = hctr_q + CTR_W'(1);
        // Bar index saturates at 7, so leftover pixels stay black
        if (bar_idx_q != 3'd7) begin
          if (bar_pos_q == BW_LAST) begin
            bar_pos_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_pos_d = bar_pos_q + CTR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      hctr_q      <= '0;
      vctr_q      <= '0;
      fctr_q      <= '0;
      xvrst_dly_q <= 1'b1;
      mode_q      <= '0;
      bar_pos_q   <= '0;
      bar_idx_q   <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      hctr_q      <= hctr_d;
      vctr_q      <= vctr_d;
      fctr_q      <= fctr_d;
      xvrst_dly_q <= xvrst_dly_d;
      mode_q      <= mode_d;
      bar_pos_q   <= bar_pos_d;
      bar_idx_q   <= bar_idx_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign QQs_R_o = r_q;
  assign QQs_G_o = g_q;
  assign QQs_B_o = b_q;
  assign DE_o    = de_q;
  assign HS_o    = hs_q;
  assign VS_o    = vs_q;
  assign HCTRs_o = hctr_q;
  assign VCTRs_o = vctr_q;
  assign FCTRs_o = fctr_q;

endmodule
`default_nettype wire

// File: tb/tb_tp_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tp_gen_multi
// Brief    : Three differently sized generators driven in lockstep and
//            compared each clock against a arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tp_gen_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;
  logic       xv  = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] fr = 8'd0, fg = 8'd0, fb = 8'd0;

  always #5 clk = ~clk;

  logic [7:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic        de0, hs0, vs0, de1, hs1, vs1, de2, hs2, vs2;
  logic [15:0] h0, v0, h1, v1, h2, v2;
  logic [7:0]  f0, f1;
  logic [3:0]  f2;

  tp_gen_multi u_dut0 (
    .CK_i(clk), .RST_i(rst), .CK_EE_i(ce), .XVRST_i(xv), .MODE_i(mode),
    .FLAT_R_i(fr), .FLAT_G_i(fg), .FLAT_B_i(fb),
    .QQs_R_o(r0), .QQs_G_o(g0), .QQs_B_o(b0), .DE_o(de0), .HS_o(hs0), .VS_o(vs0),
    .HCTRs_o(h0), .VCTRs_o(v0), .FCTRs_o(f0));

  tp_gen_multi #(.H_TOTAL(16), .H_ACT(8), .H_SYNC_S(10), .H_SYNC_W(2),
                 .V_TOTAL(4), .V_ACT(2), .V_SYNC_S(2), .V_SYNC_W(1), .CHK_LOG2(1)) u_dut1 (
    .CK_i(clk), .RST_i(rst), .CK_EE_i(ce), .XVRST_i(xv), .MODE_i(mode),
    .FLAT_R_i(fr), .FLAT_G_i(fg), .FLAT_B_i(fb),
    .QQs_R_o(r1), .QQs_G_o(g1), .QQs_B_o(b1), .DE_o(de1), .HS_o(hs1), .VS_o(vs1),
    .HCTRs_o(h1), .VCTRs_o(v1), .FCTRs_o(f1));

  tp_gen_multi #(.F_W(4), .H_TOTAL(40), .H_ACT(24), .H_SYNC_S(28), .H_SYNC_W(4),
                 .V_TOTAL(12), .V_ACT(8), .V_SYNC_S(9), .V_SYNC_W(2), .CHK_LOG2(2)) u_dut2 (
    .CK_i(clk), .RST_i(rst), .CK_EE_i(ce), .XVRST_i(xv), .MODE_i(mode),
    .FLAT_R_i(fr), .FLAT_G_i(fg), .FLAT_B_i(fb),
    .QQs_R_o(r2), .QQs_G_o(g2), .QQs_B_o(b2), .DE_o(de2), .HS_o(hs2), .VS_o(vs2),
    .HCTRs_o(h2), .VCTRs_o(v2), .FCTRs_o(f2));

  logic [79:0] obs0, obs1, obs2;
  assign obs0 = {13'd0, r0, g0, b0, de0, hs0, vs0, h0, v0, f0};
  assign obs1 = {13'd0, r1, g1, b1, de1, hs1, vs1, h1, v1, f1};
  assign obs2 = {13'd0, r2, g2, b2, de2, hs2, vs2, h2, v2, 4'd0, f2};

  // Per-instance geometry
  int p_ht [3] = '{910, 16, 40};
  int p_ha [3] = '{720, 8, 24};
  int p_hss[3] = '{736, 10, 28};
  int p_hsw[3] = '{64, 2, 4};
  int p_vt [3] = '{262, 4, 12};
  int p_va [3] = '{240, 2, 8};
  int p_vss[3] = '{244, 2, 9};
  int p_vsw[3] = '{3, 1, 2};
  int p_chk[3] = '{4, 1, 2};
  int p_fm [3] = '{256, 256, 16};
  // Bar colours as RGB bit triples, index 0..7
  int bar_col[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  int         mh[3], mv[3], mf[3], mm[3], mxd[3];
  logic [7:0] er[3], eg[3], eb[3];
  bit         ede[3], ehs[3], evs[3];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [79:0] mvec(input int k);
    logic [15:0] h, v;
    logic [7:0]  f;
    h = 16'(mh[k]);
    v = 16'(mv[k]);
    f = 8'(mf[k]);
    return {13'd0, er[k], eg[k], eb[k], ede[k], ehs[k], evs[k], h, v, f};
  endfunction

  task automatic model_step(input int k);
    int vr, idx, sel, c;
    if (rst) begin
      mh[k] = 0; mv[k] = 0; mf[k] = 0; mm[k] = 0; mxd[k] = 1;
      er[k] = 0; eg[k] = 0; eb[k] = 0; ede[k] = 0; ehs[k] = 0; evs[k] = 0;
    end else if (ce) begin
      ede[k] = (mh[k] < p_ha[k]) && (mv[k] < p_va[k]);
      ehs[k] = (mh[k] >= p_hss[k]) && (mh[k] < p_hss[k] + p_hsw[k]);
      evs[k] = (mv[k] >= p_vss[k]) && (mv[k] < p_vss[k] + p_vsw[k]);
      er[k] = 0; eg[k] = 0; eb[k] = 0;
      if (ede[k]) begin
        case (mm[k])
          0: begin
            er[k] = 8'(mh[k] % 256);
            eg[k] = 8'((mh[k] + mv[k] + mf[k]) % 256);
            eb[k] = 8'(mv[k] % 256);
          end
          1: begin
            idx = mh[k] / (p_ha[k] / 8);
            if (idx > 7) idx = 7;
            c = bar_col[idx];
            er[k] = ((c >> 2) & 1) != 0 ? 8'hff : 8'h00;
            eg[k] = ((c >> 1) & 1) != 0 ? 8'hff : 8'h00;
            eb[k] = (c & 1) != 0 ? 8'hff : 8'h00;
          end
          2: begin
            sel = ((((mh[k] + mf[k]) % 65536) >> p_chk[k]) ^ (mv[k] >> p_chk[k])) & 1;
            er[k] = sel != 0 ? 8'hff : 8'h00;
            eg[k] = er[k];
            eb[k] = er[k];
          end
          default: begin
            er[k] = fr; eg[k] = fg; eb[k] = fb;
          end
        endcase
      end
      vr = (mxd[k] != 0 && xv == 1'b0) ? 1 : 0;
      mxd[k] = int'(xv);
      if ((mh[k] == p_ht[k] - 1 && mv[k] == p_vt[k] - 1) || vr != 0) mm[k] = int'(mode);
      if (vr != 0) begin
        mh[k] = 0; mv[k] = 0;
      end else if (mh[k] == p_ht[k] - 1) begin
        mh[k] = 0;
        if (mv[k] == p_vt[k] - 1) begin
          mv[k] = 0;
          mf[k] = (mf[k] + 1) % p_fm[k];
        end else begin
          mv[k] = mv[k] + 1;
        end
      end else begin
        mh[k] = mh[k] + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    check("dflt", obs0, mvec(0));
    check("small", obs1, mvec(1));
    check("mid", obs2, mvec(2));
  endtask

  initial begin
    int guard;
    // Reset
    rst = 1'b1; ce = 1'b0;
    tick(); tick();
    check("rst_dflt", obs0, 80'd0);
    rst = 1'b0; ce = 1'b1; xv = 1'b1; mode = 2'd0;

    // Legacy pattern with 1-clock latency; small-instance first field wrap
    for (int i = 1; i <= 1825; i++) begin
      tick();
      if (i == 64) check("small_wrap1", 80'({h1, v1, f1}), 80'({16'd0, 16'd0, 8'd1}));
    end
    check("leg_pos", 80'({h0, v0, f0}), 80'({16'd5, 16'd2, 8'd0}));
    tick();
    check("leg_rgb", 80'({r0, g0, b0, de0}), 80'({8'd5, 8'd7, 8'd2, 1'b1}));
    repeat (714) tick();
    check("leg_h720", 80'(h0), 80'(16'd720));
    tick();
    check("leg_blank", 80'({r0, g0, b0, de0}), 80'd0);

    // Colour bars, mode latched by a vertical reset
    mode = 2'd1; xv = 1'b0;
    tick();
    xv = 1'b1;
    for (int i = 0; i < 720; i++) begin
      tick();
      if (i == 0 || i == 89)   check("bar_white", 80'({r0, g0, b0}), 80'(24'hffffff));
      if (i == 90)             check("bar_yellow", 80'({r0, g0, b0}), 80'(24'hffff00));
      if (i == 629)            check("bar_blue", 80'({r0, g0, b0}), 80'(24'h0000ff));
      if (i == 630 || i == 719) check("bar_black", 80'({r0, g0, b0}), 80'(24'h000000));
    end

    // Vertical reset at a chosen position of the mid instance
    mode = 2'd0; xv = 1'b0;
    tick();
    xv = 1'b1;
    guard = 0;
    while (!(mf[2] == 7 && mv[2] == 5 && mh[2] == 30)) begin
      if (mf[2] == 7 && mv[2] == 1) mode = 2'd2;
      tick();
      guard++;
      if (guard > 12000) begin
        check("vrst_bound", 80'd0, 80'd1);
        break;
      end
    end
    check("pre_vrst_mode", 80'(mode), 80'(2'd2));
    xv = 1'b0;
    tick();
    check("vrst_pos", 80'({h2, v2, 4'd0, f2}), 80'({16'd0, 16'd0, 8'd7}));
    tick();
    check("vrst_chk", 80'({r2, g2, b2, de2}), 80'({24'hffffff, 1'b1}));
    tick();
    check("vrst_once", 80'({h2, v2}), 80'({16'd2, 16'd0}));
    xv = 1'b1;

    // Clock enable one clock in three
    for (int i = 0; i < 30; i++) begin
      ce = (i % 3 == 0);
      tick();
    end
    check("ce_adv", 80'({h2, v2}), 80'({16'd12, 16'd0}));
    ce = 1'b0; xv = 1'b0;
    tick(); tick();
    check("ce_hold", 80'(h2), 80'(16'd12));
    ce = 1'b1;
    tick();
    check("ce_vrst", 80'({h2, v2}), 80'd0);
    xv = 1'b1;
    tick();

    // Mid-frame mode change takes effect at the next field only
    mode = 2'd0; xv = 1'b0;
    tick();
    xv = 1'b1;
    guard = 0;
    while (mv[2] != 3 && guard < 1000) begin tick(); guard++; end
    mode = 2'd3; fr = 8'h3c; fg = 8'ha5; fb = 8'h17;
    tick();
    check("mid_keep", 80'({r2, b2}), 80'({8'(mh[2] - 1), 8'd3}));
    guard = 0;
    while (!(mh[2] == 0 && mv[2] == 0) && guard < 1000) begin tick(); guard++; end
    if (guard >= 1000) check("flat_bound", 80'd0, 80'd1);
    tick();
    check("flat_first", 80'({r2, g2, b2, de2}), 80'({8'h3c, 8'ha5, 8'h17, 1'b1}));

    // Field counter wrap on the small instance
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 2'd0;
    for (int i = 1; i <= 256 * 64; i++) begin
      tick();
      if (i == 255 * 64) check("small_f255", 80'(f1), 80'(8'd255));
    end
    check("small_fwrap", 80'({h1, v1, f1}), 80'd0);

    // Randomised run
    for (int i = 0; i < 8000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 29) == 0) xv = ~xv;
      fr = 8'($urandom); fg = 8'($urandom); fb = 8'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    // Reset mid-line with clock enable low
    rst = 1'b0; ce = 1'b1; mode = 2'd3; fr = 8'h5a; fg = 8'h5a; fb = 8'h5a; xv = 1'b0;
    tick();
    xv = 1'b1;
    repeat (10) tick();
    check("pre_rst_de", 80'({r0, de0}), 80'({8'h5a, 1'b1}));
    ce = 1'b0; rst = 1'b1;
    tick();
    check("rst_ce0_dflt", obs0, 80'd0);
    check("rst_ce0_mid", obs2, 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
